fifo_burst_writer: RTL
======================

# fifo_burst_writer

Producer-side write engine that sits directly upstream of the asynchronous FIFO in the producer clock domain. On a start command it generates a burst of up to `P_MAX_BURST` words, following the same arithmetic pattern the transaction model uses, and pushes them into the FIFO write port. It honours FIFO full back-pressure and inserts a programmable number of idle cycles between writes. It replaces the behavioural producer with synthesizable RTL.

## Interface
Parameters:
- `P_DATA_WIDTH`, default 8: width of the FIFO write data.
- `P_MAX_BURST`, default 1024: maximum words per burst.
- `P_IDLE_WIDTH`, default 4: width of the idle-gap control.

Ports (`LW = $clog2(P_MAX_BURST+1)`):
- `PROD_CLK` in, 1 bit: producer clock. This block has one clock only.
- `PROD_RST` in, 1 bit: reset, synchronous and active-high.
- `I_START` in, 1 bit: burst request. Sampled only in IDLE.
- `I_BURST_LEN` in, `LW` bits: number of words. Latched on an accepted start.
- `I_SEED` in, `P_DATA_WIDTH` bits: pattern multiplier. Latched on an accepted start.
- `I_WR_IDLE` in, `P_IDLE_WIDTH` bits: idle cycles after each write. Latched on an accepted start.
- `I_FULL` in, 1 bit: FIFO full flag, already synchronized to `PROD_CLK`.
- `O_WR_EN` out, 1 bit: FIFO write strobe.
- `O_WR_DATA` out, `P_DATA_WIDTH` bits: FIFO write data.
- `O_BUSY` out, 1 bit: high in every state except IDLE.
- `O_DONE` out, 1 bit: one-cycle pulse when the burst completes.
- `O_COUNT` out, `LW` bits: words accepted so far in the current burst.

## Operation
- FSM states: IDLE, WRITE, GAP, DONE.
- IDLE:
  - On `I_START`=1, latch len/seed/idle, clear the count, and go to WRITE.
  - If the latched len is 0, go to DONE instead.
  - If `I_BURST_LEN` > `P_MAX_BURST`, clamp len to `P_MAX_BURST`.
- WRITE:
  - `O_WR_EN = (state==WRITE) && !I_FULL`. This is combinational from `I_FULL`; no write is ever issued while full.
  - On an accepted write (`O_WR_EN`=1), increment the count.
    - If the new count equals len, go to DONE.
    - Otherwise, if idle is nonzero, go to GAP with the gap counter set to idle.
    - Otherwise stay in WRITE.
  - While `I_FULL`=1, hold state, count and data indefinitely.
- GAP: decrement the gap counter each cycle. When it reaches 0, go to WRITE. `I_FULL` is ignored in GAP. No gap is inserted after the last word.
- DONE: `O_DONE`=1 for exactly one cycle, then go to IDLE.
- `I_START` is ignored outside IDLE. A start asserted in the DONE cycle is ignored.
- Data pattern:
  - `O_WR_DATA = seed*count + 1`, truncated to `P_DATA_WIDTH` (modulo 2^W wrap).
  - The value is registered and updated on each accepted write and on start, so it is valid whenever `O_WR_EN`=1.
- Reset mid-operation: on the next `PROD_CLK` edge the block returns to IDLE with all registers cleared. No further writes are issued. A partially written burst is not resumed.

## Timing
- All outputs are 0 after reset: `O_WR_EN`, `O_WR_DATA`, `O_BUSY`, `O_DONE`, `O_COUNT`.
- Start latency: `I_START` is sampled at edge t. The first `O_WR_EN` occurs in cycle t+1 if `I_FULL`=0.
- Throughput with no back-pressure: one write every `I_WR_IDLE`+1 cycles.
- A burst of L words with idle N and no full takes L + (L-1)·N cycles of WRITE/GAP, then one DONE cycle.
- `O_DONE` is asserted in the cycle after the last write. `O_BUSY` falls in the cycle after `O_DONE`.
- A len-0 burst gives `O_DONE` at t+1 with no writes.
- `O_COUNT` reflects accepted writes as of the previous edge. It holds its final value through DONE and IDLE until the next accepted start.

## Structure
- Shared package `ccd_prod_pkg` holds:
  - the state enum `prod_state_e` (IDLE, WRITE, GAP, DONE);
  - a function computing `LW` from the max burst;
  - default constants for data width (8) and max burst (1024).
- Single module with no sub-module. The FSM, gap counter, word counter and pattern register are all small.

## Test plan
- Basic burst: len=4, seed=1, idle=0, full=0 → writes on 4 consecutive cycles with data 1,2,3,4; `O_DONE` on the 5th cycle after start; `O_COUNT`=4.
- Idle gap: len=3, seed=2, idle=2 → `O_WR_EN` at cycles 1, 4, 7 with data 1,3,5; `O_DONE` at cycle 8.
- Back-pressure: len=4, idle=0, `I_FULL` high during cycles 2–5 → writes at cycle 1 and then cycles 6–8; data sequence 1,2,3,4 with no gaps, drops or duplicates; no `O_WR_EN` while full.
- Boundaries:
  - len=0 → no writes, `O_DONE` at cycle 1.
  - len=1025 → exactly 1024 writes.
  - seed=3, len=100 → data wraps modulo 256; word 85 = 0x00.
- Reset mid-burst: assert `PROD_RST` after 5 of 10 writes → the next edge gives all outputs 0 and no further writes. A new start then delivers a full fresh burst beginning at data 1.
- Start while busy: pulse `I_START` with len=7 during a len=3 burst → exactly 3 writes; the second command is ignored.

Source files
------------

// File: rtl/ccd_prod_pkg.sv
// Shared definitions for the producer-side FIFO write engine.
//   prod_state_e    : write-engine FSM states
//   calc_lw()       : width of a burst-length / word-count field for a given max burst
//   DEF_DATA_WIDTH  : default FIFO data width
//   DEF_MAX_BURST   : default maximum words per burst
package ccd_prod_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_DONE
  } prod_state_e;

  // Enough bits to hold every value 0..max_burst inclusive.
  function automatic int calc_lw(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_writer.sv
// Producer-domain burst write engine feeding the async FIFO write port.
// Generates seed*k+1 (mod 2^W) for k = 0..len-1, honours FIFO full and
// inserts a programmable idle gap between writes.
//
// Ports:
//   PROD_CLK    in   producer clock
//   PROD_RST    in   synchronous active-high reset
//   I_START     in   burst request, sampled in IDLE only
//   I_BURST_LEN in   words per burst (clamped to P_MAX_BURST), latched on start
//   I_SEED      in   pattern multiplier, latched on start
//   I_WR_IDLE   in   idle cycles after each non-final write, latched on start
//   I_FULL      in   FIFO full, already synchronous to PROD_CLK
//   O_WR_EN     out  FIFO write strobe (WRITE state and not full)
//   O_WR_DATA   out  FIFO write data
//   O_BUSY      out  high outside IDLE
//   O_DONE      out  one-cycle pulse after the last write
//   O_COUNT     out  words accepted in the current/last burst
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for I_START; count/data hold the last burst's values
// WRITE | strobing the FIFO whenever it is not full
// GAP   | counting idle cycles between two writes, full is ignored
// DONE  | one-cycle completion pulse, start requests ignored
module fifo_burst_writer
  import ccd_prod_pkg::*;
#(
  parameter int P_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int P_MAX_BURST  = DEF_MAX_BURST,
  parameter int P_IDLE_WIDTH = 4
) (
  input  logic                                PROD_CLK,
  input  logic                                PROD_RST,
  input  logic                                I_START,
  input  logic [calc_lw(P_MAX_BURST)-1:0]     I_BURST_LEN,
  input  logic [P_DATA_WIDTH-1:0]             I_SEED,
  input  logic [P_IDLE_WIDTH-1:0]             I_WR_IDLE,
  input  logic                                I_FULL,
  output logic                                O_WR_EN,
  output logic [P_DATA_WIDTH-1:0]             O_WR_DATA,
  output logic                                O_BUSY,
  output logic                                O_DONE,
  output logic [calc_lw(P_MAX_BURST)-1:0]     O_COUNT
);

  localparam int LW = calc_lw(P_MAX_BURST);

  localparam logic [LW-1:0]           MAX_LEN  = LW'(P_MAX_BURST);
  localparam logic [LW-1:0]           LEN_ONE  = LW'(1);
  localparam logic [P_DATA_WIDTH-1:0] DATA_ONE = P_DATA_WIDTH'(1);
  localparam logic [P_IDLE_WIDTH-1:0] GAP_ONE  = P_IDLE_WIDTH'(1);

  prod_state_e               state_q;
  logic [LW-1:0]             len_q;
  logic [P_DATA_WIDTH-1:0]   seed_q;
  logic [P_IDLE_WIDTH-1:0]   idle_q;
  logic [P_IDLE_WIDTH-1:0]   gap_q;
  logic [LW-1:0]             count_q;
  logic [P_DATA_WIDTH-1:0]   data_q;

  logic [LW-1:0]             start_len;
  logic [LW-1:0]             count_d;
  logic                      wr_en;

  assign start_len = (I_BURST_LEN > MAX_LEN) ? MAX_LEN : I_BURST_LEN;
  assign count_d   = count_q + LEN_ONE;
  // Combinational from I_FULL so a write is never issued into a full FIFO.
  assign wr_en     = (state_q == ST_WRITE) && !I_FULL;

  always_ff @(posedge PROD_CLK) begin
    if (PROD_RST) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      seed_q  <= '0;
      idle_q  <= '0;
      gap_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (I_START) begin
            len_q   <= start_len;
            seed_q  <= I_SEED;
            idle_q  <= I_WR_IDLE;
            count_q <= '0;
            data_q  <= DATA_ONE;  // seed*0 + 1
            state_q <= (start_len == '0) ? ST_DONE : ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wr_en) begin
            count_q <= count_d;
            // Pre-compute the next word so it is ready when WRITE resumes.
            data_q  <= seed_q * P_DATA_WIDTH'(count_d) + DATA_ONE;
            if (count_d == len_q) begin
              state_q <= ST_DONE;
            end else if (idle_q != '0) begin
              state_q <= ST_GAP;
              gap_q   <= idle_q;
            end
          end
        end
        ST_GAP: begin
          gap_q <= gap_q - GAP_ONE;
          if (gap_q == GAP_ONE) begin
            state_q <= ST_WRITE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign O_WR_EN   = wr_en;
  assign O_WR_DATA = data_q;
  assign O_BUSY    = (state_q != ST_IDLE);
  assign O_DONE    = (state_q == ST_DONE);
  assign O_COUNT   = count_q;

endmodule
